// File: rtl/axi4stream_generator_s00_axi_regs_if.sv
// AXI4-Lite bus bundle between the stream generator register block and its bus master.
// The master modport drives requests, and the slave modport drives ready, response and read data.
interface axi4stream_generator_s00_axi_regs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4stream_generator_s00_axi_regs.sv
// AXI4-Lite register block for the stream generator: CTRL, LENGTH, SEED and SCRATCH.
// Define AXI4STREAM_GENERATOR_WSTRB_EN to honour per-byte write strobes; without it, every write updates the full word.
module axi4stream_generator_s00_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    axi4stream_generator_s00_axi_regs_if.slave  s00_axi,
    output logic                                gen_enable,
    output logic                                gen_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       gen_length,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       gen_seed,
    input  logic                                gen_busy
);
    localparam int NUM_REGS  = 4;
    localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;
    localparam int SEL_MSB   = C_S_AXI_ADDR_WIDTH - 1;

    logic                          ready_en_reg;
    logic                          aw_held_reg;
    logic                          w_held_reg;
    logic [1:0]                    aw_sel_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_reg;
    logic [NUM_LANES-1:0]          w_strb_reg;
    logic                          bvalid_reg;
    logic                          rvalid_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;
    logic                          gen_start_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_reg [0:NUM_REGS-1];

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          commit;
    logic [NUM_LANES-1:0]          lane_en;
    logic [C_S_AXI_DATA_WIDTH-1:0] merged;
    logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_masked;
    logic [C_S_AXI_DATA_WIDTH-1:0] read_value;
    logic                          unused_bits;

    // ready_en_reg keeps all ready outputs low for the first cycle after reset.
    assign s00_axi.awready = ready_en_reg && !aw_held_reg && !bvalid_reg;
    assign s00_axi.wready  = ready_en_reg && !w_held_reg && !bvalid_reg;
    assign s00_axi.arready = ready_en_reg && !rvalid_reg;
    assign s00_axi.bvalid  = bvalid_reg;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.rvalid  = rvalid_reg;
    assign s00_axi.rdata   = rdata_reg;
    assign s00_axi.rresp   = 2'b00;

    assign aw_hs  = s00_axi.awvalid && s00_axi.awready;
    assign w_hs   = s00_axi.wvalid && s00_axi.wready;
    assign ar_hs  = s00_axi.arvalid && s00_axi.arready;
    assign commit = aw_held_reg && w_held_reg;

`ifdef AXI4STREAM_GENERATOR_WSTRB_EN
    assign lane_en     = w_strb_reg;
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                           s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};
`else
    assign lane_en     = {NUM_LANES{1'b1}};
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, w_strb_reg,
                           s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = lane_en[gi] ? w_data_reg[gi*8 +: 8]
                                                   : regs_reg[aw_sel_reg][gi*8 +: 8];
        end
    endgenerate

    // Bit 1 (start) is never stored, and bit 31 is replaced by gen_busy on reads.
    assign ctrl_masked = {1'b0, merged[C_S_AXI_DATA_WIDTH-2:2], 1'b0, merged[0]};

    always_comb begin
        read_value = regs_reg[s00_axi.araddr[SEL_MSB:2]];
        if (s00_axi.araddr[SEL_MSB:2] == 2'd0) begin
            read_value = {gen_busy, regs_reg[0][C_S_AXI_DATA_WIDTH-2:0]};
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            ready_en_reg  <= 1'b0;
            aw_held_reg   <= 1'b0;
            w_held_reg    <= 1'b0;
            aw_sel_reg    <= '0;
            w_data_reg    <= '0;
            w_strb_reg    <= '0;
            bvalid_reg    <= 1'b0;
            gen_start_reg <= 1'b0;
        end else begin
            ready_en_reg  <= 1'b1;
            gen_start_reg <= commit && (aw_sel_reg == 2'd0) && lane_en[0] && w_data_reg[1];
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_sel_reg  <= s00_axi.awaddr[SEL_MSB:2];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                w_data_reg <= s00_axi.wdata;
                w_strb_reg <= s00_axi.wstrb;
            end
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
            end else if (bvalid_reg && s00_axi.bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (aw_sel_reg == 2'(i)) begin
                    regs_reg[i] <= (i == 0) ? ctrl_masked : merged;
                end
            end
        end
    end

    // A read in the same cycle as a commit captures the value from before the write.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= read_value;
        end else if (rvalid_reg && s00_axi.rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign gen_enable = regs_reg[0][0];
    assign gen_start  = gen_start_reg;
    assign gen_length = regs_reg[1];
    assign gen_seed   = regs_reg[2];
endmodule

// File: tb/tb_axi4stream_generator_s00_axi_regs.sv
// Directed bench for the stream generator AXI4-Lite register block.
// Each task drives one scenario and checks the results against hand-computed values.
module tb_axi4stream_generator_s00_axi_regs;
    logic        clk;
    logic        aresetn;
    logic        gen_enable;
    logic        gen_start;
    logic [31:0] gen_length;
    logic [31:0] gen_seed;
    logic        gen_busy;
    int          checks;
    int          errors;
    int          start_cnt;

    axi4stream_generator_s00_axi_regs_if s00_axi ();

    axi4stream_generator_s00_axi_regs dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi         (s00_axi),
        .gen_enable      (gen_enable),
        .gen_start       (gen_start),
        .gen_length      (gen_length),
        .gen_seed        (gen_seed),
        .gen_busy        (gen_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gen_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_pend, w_pend, aw_go, w_go;
        int n;
        s00_axi.awaddr  = addr;
        s00_axi.awvalid = 1'b1;
        s00_axi.wdata   = data;
        s00_axi.wstrb   = strb;
        s00_axi.wvalid  = 1'b1;
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        n = 0;
        while ((aw_pend || w_pend) && n < 50) begin
            aw_go = s00_axi.awvalid && s00_axi.awready;
            w_go  = s00_axi.wvalid && s00_axi.wready;
            tick();
            if (aw_go) begin s00_axi.awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_go)  begin s00_axi.wvalid  = 1'b0; w_pend  = 1'b0; end
            n++;
        end
        n = 0;
        while (!s00_axi.bvalid && n < 50) begin tick(); n++; end
        checks++;
        if (s00_axi.bvalid !== 1'b1) begin
            $display("FAIL write_timeout addr=%h got bvalid=%b want 1", addr, s00_axi.bvalid);
            errors++;
        end
        resp = s00_axi.bresp;
        s00_axi.awvalid = 1'b0;
        s00_axi.wvalid  = 1'b0;
        s00_axi.bready  = 1'b1;
        tick();
        s00_axi.bready  = 1'b0;
        $display("write addr=%h data=%h strb=%b resp=%b", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        s00_axi.araddr  = addr;
        s00_axi.arvalid = 1'b1;
        n = 0;
        while (!s00_axi.arready && n < 50) begin tick(); n++; end
        tick();
        s00_axi.arvalid = 1'b0;
        n = 0;
        while (!s00_axi.rvalid && n < 50) begin tick(); n++; end
        checks++;
        if (s00_axi.rvalid !== 1'b1) begin
            $display("FAIL read_timeout addr=%h got rvalid=%b want 1", addr, s00_axi.rvalid);
            errors++;
        end
        data = s00_axi.rdata;
        resp = s00_axi.rresp;
        s00_axi.rready = 1'b1;
        tick();
        s00_axi.rready = 1'b0;
        $display("read  addr=%h data=%h resp=%b", addr, data, resp);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        checks++;
        if ({s00_axi.awready, s00_axi.wready, s00_axi.arready, s00_axi.bvalid,
             s00_axi.rvalid, gen_start, gen_enable} !== 7'b0) begin
            $display("FAIL reset_ctrl got %b want 0000000", {s00_axi.awready, s00_axi.wready,
                     s00_axi.arready, s00_axi.bvalid, s00_axi.rvalid, gen_start, gen_enable});
            errors++;
        end
        checks++;
        if ({s00_axi.rdata, gen_length, gen_seed} !== 96'b0) begin
            $display("FAIL reset_data got rdata=%h len=%h seed=%h want 0", s00_axi.rdata,
                     gen_length, gen_seed);
            errors++;
        end
        aresetn = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, r);
            checks++;
            if (r !== 2'b00) begin
                $display("FAIL basic_bresp idx=%0d got %b want 00", i, r);
                errors++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r);
            checks++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                $display("FAIL basic_read idx=%0d got %h/%b want %h/00", i, d, r, 32'(i + 1));
                errors++;
            end
        end
        checks++;
        if (gen_length !== 32'd2 || gen_seed !== 32'd3) begin
            $display("FAIL basic_outputs got len=%h seed=%h want 2/3", gen_length, gen_seed);
            errors++;
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r;
        s00_axi.wdata  = 32'hDEADBEEF;
        s00_axi.wstrb  = 4'hF;
        s00_axi.wvalid = 1'b1;
        s00_axi.awaddr = 4'h4;
        checks++;
        if (s00_axi.wready !== 1'b1) begin
            $display("FAIL wfirst_wready got %b want 1", s00_axi.wready);
            errors++;
        end
        tick();
        s00_axi.wvalid = 1'b0;
        tick();
        tick();
        s00_axi.awvalid = 1'b1;
        tick();
        s00_axi.awvalid = 1'b0;
        checks++;
        if (s00_axi.bvalid !== 1'b0) begin
            $display("FAIL wfirst_bvalid_early got %b want 0", s00_axi.bvalid);
            errors++;
        end
        tick();
        checks++;
        if (s00_axi.bvalid !== 1'b1) begin
            $display("FAIL wfirst_bvalid got %b want 1", s00_axi.bvalid);
            errors++;
        end
        s00_axi.bready = 1'b1;
        tick();
        s00_axi.bready = 1'b0;
        checks++;
        if (s00_axi.bvalid !== 1'b0) begin
            $display("FAIL wfirst_single_b got %b want 0", s00_axi.bvalid);
            errors++;
        end
        axi_read(4'h4, d, r);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            $display("FAIL wfirst_length got %h want deadbeef", d);
            errors++;
        end
    endtask

    task automatic test_b_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        s00_axi.awaddr  = 4'h8;
        s00_axi.wdata   = 32'h00000055;
        s00_axi.wstrb   = 4'hF;
        s00_axi.awvalid = 1'b1;
        s00_axi.wvalid  = 1'b1;
        tick();
        s00_axi.awvalid = 1'b0;
        s00_axi.wvalid  = 1'b0;
        tick();
        s00_axi.wdata   = 32'h00000066;
        s00_axi.awvalid = 1'b1;
        s00_axi.wvalid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({s00_axi.bvalid, s00_axi.awready, s00_axi.wready} !== 3'b100) begin
                $display("FAIL bp_hold cyc=%0d got bvalid/awready/wready=%b want 100", i,
                         {s00_axi.bvalid, s00_axi.awready, s00_axi.wready});
                errors++;
            end
            tick();
        end
        s00_axi.bready = 1'b1;
        tick();
        s00_axi.bready = 1'b0;
        checks++;
        if (s00_axi.bvalid !== 1'b0 || gen_seed !== 32'h00000055) begin
            $display("FAIL bp_release got bvalid=%b seed=%h want 0/00000055", s00_axi.bvalid,
                     gen_seed);
            errors++;
        end
        tick();
        s00_axi.awvalid = 1'b0;
        s00_axi.wvalid  = 1'b0;
        tick();
        checks++;
        if (s00_axi.bvalid !== 1'b1) begin
            $display("FAIL bp_second_b got %b want 1", s00_axi.bvalid);
            errors++;
        end
        s00_axi.bready = 1'b1;
        tick();
        s00_axi.bready = 1'b0;
        axi_read(4'h8, d, r);
        checks++;
        if (d !== 32'h00000066) begin
            $display("FAIL bp_seed got %h want 00000066", d);
            errors++;
        end
    endtask

    task automatic test_ctrl_start();
        logic [31:0] d;
        logic [1:0]  r;
        start_cnt = 0;
        axi_write(4'h0, 32'h00000003, 4'hF, r);
        tick();
        tick();
        checks++;
        if (start_cnt !== 1 || gen_enable !== 1'b1) begin
            $display("FAIL ctrl_start got pulses=%0d enable=%b want 1/1", start_cnt, gen_enable);
            errors++;
        end
        axi_read(4'h0, d, r);
        checks++;
        if (d !== 32'h00000001) begin
            $display("FAIL ctrl_read got %h want 00000001", d);
            errors++;
        end
        gen_busy = 1'b1;
        axi_read(4'h0, d, r);
        gen_busy = 1'b0;
        checks++;
        if (d !== 32'h80000001) begin
            $display("FAIL ctrl_busy got %h want 80000001", d);
            errors++;
        end
        axi_write(4'h0, 32'h00000001, 4'hF, r);
        tick();
        checks++;
        if (start_cnt !== 1) begin
            $display("FAIL ctrl_nostart got pulses=%0d want 1", start_cnt);
            errors++;
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] want;
`ifdef AXI4STREAM_GENERATOR_WSTRB_EN
        want = 32'h11BB33DD;
`else
        want = 32'hAABBCCDD;
`endif
        axi_write(4'h8, 32'h11223344, 4'hF, r);
        axi_write(4'h8, 32'hAABBCCDD, 4'b0101, r);
        axi_read(4'h8, d, r);
        checks++;
        if (d !== want) begin
            $display("FAIL strobe_seed got %h want %h", d, want);
            errors++;
        end
    endtask

    task automatic test_reset_mid_aw();
        logic [31:0] d;
        logic [1:0]  r;
        s00_axi.awaddr  = 4'h4;
        s00_axi.awvalid = 1'b1;
        tick();
        s00_axi.awvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        checks++;
        if (s00_axi.awready !== 1'b0 || s00_axi.bvalid !== 1'b0) begin
            $display("FAIL rst_mid_state got awready=%b bvalid=%b want 0/0", s00_axi.awready,
                     s00_axi.bvalid);
            errors++;
        end
        tick();
        s00_axi.wdata  = 32'h00000077;
        s00_axi.wstrb  = 4'hF;
        s00_axi.wvalid = 1'b1;
        tick();
        s00_axi.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s00_axi.bvalid !== 1'b0) begin
                $display("FAIL rst_mid_nob cyc=%0d got bvalid=%b want 0", i, s00_axi.bvalid);
                errors++;
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r);
            checks++;
            if (d !== 32'h0) begin
                $display("FAIL rst_mid_reg idx=%0d got %h want 00000000", i, d);
                errors++;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start_cnt = 0;
        gen_busy = 1'b0;
        aresetn = 1'b0;
        s00_axi.awaddr  = '0;
        s00_axi.awprot  = '0;
        s00_axi.awvalid = 1'b0;
        s00_axi.wdata   = '0;
        s00_axi.wstrb   = '0;
        s00_axi.wvalid  = 1'b0;
        s00_axi.bready  = 1'b0;
        s00_axi.araddr  = '0;
        s00_axi.arprot  = '0;
        s00_axi.arvalid = 1'b0;
        s00_axi.rready  = 1'b0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_b_backpressure();
        test_ctrl_start();
        test_strobe();
        test_reset_mid_aw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
